// File: rtl/twpm_pkg.sv
// twpm_pkg: register map, read default and IRQ bit indices shared by the TPM command mailbox.
package twpm_pkg;
  localparam logic [16:0] STATUS        = 17'h00000;
  localparam logic [16:0] OP_TYPE       = 17'h00004;
  localparam logic [16:0] LOCALITY      = 17'h00008;
  localparam logic [16:0] BUF_SIZE      = 17'h0000C;
  localparam logic [16:0] IRQ_EN        = 17'h00010;
  localparam logic [16:0] IRQ_STAT      = 17'h00014;
  localparam logic [16:0] COMPLETE      = 17'h00040;
  localparam logic [16:0] FPGA_RAM_BASE = 17'h00800;
  localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;
  localparam int IRQ_EXEC  = 0;
  localparam int IRQ_ABORT = 1;
  typedef enum logic [2:0] {R_STATUS, R_OP, R_LOC, R_BUF, R_EN, R_STAT, R_CMPL, R_NONE} reg_e;
  function automatic reg_e reg_decode(input logic [14:0] wa);
    return wa == STATUS[16:2]   ? R_STATUS :
           wa == OP_TYPE[16:2]  ? R_OP     :
           wa == LOCALITY[16:2] ? R_LOC    :
           wa == BUF_SIZE[16:2] ? R_BUF    :
           wa == IRQ_EN[16:2]   ? R_EN     :
           wa == IRQ_STAT[16:2] ? R_STAT   :
           wa == COMPLETE[16:2] ? R_CMPL   : R_NONE;
  endfunction
endpackage

// File: rtl/twpm_sync_edge.sv
// twpm_sync_edge: 2-flop synchroniser for an LCLK-domain flag plus rising-edge detect in wb_clk.
module twpm_sync_edge (
  input  logic wb_clk,
  input  logic nrst_i,
  input  logic d,
  output logic q,
  output logic rise
);
  logic m, p;
  always_ff @(posedge wb_clk or negedge nrst_i)
    if (!nrst_i) {m, q, p} <= 3'b000;
    else {m, q, p} <= {d, m, q};
  assign rise = q & ~p;
endmodule

// File: rtl/twpm_cmd_mailbox.sv
// twpm_cmd_mailbox: Wishbone mailbox between the CPU and the LPC-side TPM registers / shared RAM;
// snapshots commands, raises the CPU interrupt, gates RAM ownership and drives the complete pulse.
module twpm_cmd_mailbox #(
  parameter int          RAM_ADDR_WIDTH       = 11,
  parameter int          COMPLETE_PULSE_WIDTH = 20,
  parameter logic [31:0] DEFAULT_READ_VALUE   = twpm_pkg::DEFAULT_READ_VALUE
) (
  input  logic                      wb_clk,
  input  logic                      nrst_i,
  input  logic [16:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic                      exec_a_i,
  input  logic                      abort_a_i,
  input  logic [3:0]                op_type_i,
  input  logic [3:0]                locality_i,
  input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
  input  logic [31:0]               ram_rd_i,
  output logic [RAM_ADDR_WIDTH-3:0] ram_adr_o,
  output logic [3:0]                ram_wen_o,
  output logic                      complete_o,
  output logic                      irq_o
);
  localparam logic [16:0] RAM_TAG = twpm_pkg::FPGA_RAM_BASE >> RAM_ADDR_WIDTH;
  logic exec_s, exec_r, abort_s, abort_r;
  logic req, wr, in_ram, ram_q, err_nxt;
  logic [3:0] op_q, loc_q;
  logic [RAM_ADDR_WIDTH-1:0] len_q;
  logic [1:0] irq_en, irq_stat, irq_set, irq_clr;
  logic [7:0] cnt, cnt_nxt;
  logic [31:0] rd_nxt, dat_q;
  twpm_pkg::reg_e rsel;
  logic unused;
  twpm_sync_edge u_exec (.wb_clk(wb_clk), .nrst_i(nrst_i), .d(exec_a_i), .q(exec_s), .rise(exec_r));
  twpm_sync_edge u_abort (.wb_clk(wb_clk), .nrst_i(nrst_i), .d(abort_a_i), .q(abort_s), .rise(abort_r));
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = req & wb_we_i;
  assign in_ram    = wb_adr_i[16:RAM_ADDR_WIDTH] == RAM_TAG[16-RAM_ADDR_WIDTH:0];
  assign rsel      = twpm_pkg::reg_decode(wb_adr_i[16:2]);
  assign ram_adr_o = wb_adr_i[RAM_ADDR_WIDTH-1:2];
  assign ram_wen_o = (wr & in_ram & exec_s) ? wb_sel_i : 4'b0000;
  assign wb_dat_o  = ram_q ? ram_rd_i : dat_q;
  assign unused    = ^{wb_dat_i[31:2], wb_adr_i[1:0]};
  always_comb begin
    irq_set = 2'b00;
    irq_set[twpm_pkg::IRQ_EXEC]  = exec_r;
    irq_set[twpm_pkg::IRQ_ABORT] = abort_r;
    irq_clr = (wr && !in_ram && rsel == twpm_pkg::R_STAT && wb_sel_i[0]) ? wb_dat_i[1:0] : 2'b00;
    cnt_nxt = (wr && !in_ram && rsel == twpm_pkg::R_CMPL && wb_sel_i != 4'b0000 && cnt == 8'd0) ?
              8'(COMPLETE_PULSE_WIDTH) : (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
    rd_nxt = in_ram                     ? DEFAULT_READ_VALUE :
             rsel == twpm_pkg::R_STATUS ? {28'b0, irq_o, complete_o, abort_s, exec_s} :
             rsel == twpm_pkg::R_OP     ? {28'b0, op_q} :
             rsel == twpm_pkg::R_LOC    ? {28'b0, loc_q} :
             rsel == twpm_pkg::R_BUF    ? {{(32-RAM_ADDR_WIDTH){1'b0}}, len_q} :
             rsel == twpm_pkg::R_EN     ? {30'b0, irq_en} :
             rsel == twpm_pkg::R_STAT   ? {30'b0, irq_stat} : DEFAULT_READ_VALUE;
    err_nxt = in_ram ? ~exec_s :
              wb_we_i & ~(rsel == twpm_pkg::R_EN || rsel == twpm_pkg::R_STAT || rsel == twpm_pkg::R_CMPL);
  end
  // Decode is resolved in the request cycle; the ack cycle only muxes in the RAM's late read data.
  always_ff @(posedge wb_clk or negedge nrst_i)
    if (!nrst_i) begin
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      dat_q      <= '0;
      ram_q      <= 1'b0;
      op_q       <= '0;
      loc_q      <= '0;
      len_q      <= '0;
      irq_en     <= '0;
      irq_stat   <= '0;
      irq_o      <= 1'b0;
      cnt        <= '0;
      complete_o <= 1'b0;
    end else begin
      wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
      wb_err_o <= req & err_nxt;
      if (req) begin
        dat_q <= rd_nxt;
        ram_q <= in_ram & exec_s;
      end
      if (exec_r) begin
        op_q  <= op_type_i;
        loc_q <= locality_i;
        len_q <= buf_len_i;
      end
      if (wr && !in_ram && rsel == twpm_pkg::R_EN && wb_sel_i[0]) irq_en <= wb_dat_i[1:0];
      irq_stat   <= (irq_stat & ~irq_clr) | irq_set;
      irq_o      <= |(irq_stat & irq_en);
      cnt        <= cnt_nxt;
      complete_o <= cnt_nxt != 8'd0;
    end
endmodule

// File: tb/tb_twpm_cmd_mailbox.sv
// tb_twpm_cmd_mailbox: scoreboard bench; stimulus pushes expected responses, a monitor checks them at ack.
module tb_twpm_cmd_mailbox;
  import twpm_pkg::*;
  logic wb_clk = 0, nrst_i = 0;
  logic [16:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0, wb_dat_o, ram_rd_i;
  logic wb_we_i = 0, wb_stb_i = 0, wb_cyc_i = 0, wb_ack_o, wb_err_o;
  logic [3:0] wb_sel_i = '0, op_type_i = '0, locality_i = '0, ram_wen_o;
  logic [10:0] buf_len_i = '0;
  logic [8:0] ram_adr_o;
  logic exec_a_i = 0, abort_a_i = 0, complete_o, irq_o;

  twpm_cmd_mailbox dut (
    .wb_clk(wb_clk), .nrst_i(nrst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .exec_a_i(exec_a_i), .abort_a_i(abort_a_i),
    .op_type_i(op_type_i), .locality_i(locality_i), .buf_len_i(buf_len_i), .ram_rd_i(ram_rd_i),
    .ram_adr_o(ram_adr_o), .ram_wen_o(ram_wen_o), .complete_o(complete_o), .irq_o(irq_o)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct { string n; logic [31:0] d; logic e; logic c; } exp_t;
  typedef struct { string n; logic [31:0] a; logic [31:0] e; } d_t;
  exp_t q[$];
  d_t dq[$];
  int tests = 0, fails = 0;

  // Synchronous RAM behind the mailbox, and the bench's own picture of what it should hold.
  logic [31:0] mem[512];
  logic [31:0] shadow[512];
  bit ram_init;
  always @(posedge wb_clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'(i) * 32'h9E3779B1;
      ram_init <= 1'b1;
    end else
      for (int b = 0; b < 4; b++) if (ram_wen_o[b]) mem[ram_adr_o][8*b +: 8] <= wb_dat_i[8*b +: 8];
    ram_rd_i <= mem[ram_adr_o];
  end

  logic [1:0] m_en = 0, m_stat = 0;
  logic [3:0] m_op = 0, m_loc = 0;
  logic [10:0] m_len = 0;
  logic m_exec = 0, m_abort = 0;

  int hi_cnt = 0, rises = 0, wen_cnt = 0;
  logic cpl_d = 0;
  logic [3:0] last_wen = 0;
  logic [8:0] last_adr = 0;

  always @(negedge wb_clk) begin
    exp_t x;
    d_t y;
    if (complete_o) hi_cnt++;
    if (complete_o && !cpl_d) rises++;
    cpl_d = complete_o;
    if (ram_wen_o != 4'b0) begin wen_cnt++; last_wen = ram_wen_o; last_adr = ram_adr_o; end
    while (dq.size() > 0) begin
      y = dq.pop_front();
      tests++;
      if (y.a !== y.e) begin fails++; $display("FAIL %s: got %h expected %h", y.n, y.a, y.e); end
    end
    if (wb_ack_o) begin
      tests++;
      if (q.size() == 0) begin fails++; $display("FAIL unexpected_ack: got ack with empty scoreboard"); end
      else begin
        x = q.pop_front();
        if (wb_err_o !== x.e || (x.c && wb_dat_o !== x.d)) begin
          fails++;
          $display("FAIL %s: got dat=%h err=%b expected dat=%h err=%b (dat checked=%b)",
                   x.n, wb_dat_o, wb_err_o, x.d, x.e, x.c);
        end
      end
    end
  end

  task automatic dchk(input string n, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{n, a, e});
  endtask

  function automatic logic is_ram(input logic [16:0] a);
    return a[16:11] == 6'd1;
  endfunction

  function automatic logic [31:0] model_rd(input logic [16:0] a);
    if (is_ram(a)) return m_exec ? shadow[a[10:2]] : 32'hBADFABAC;
    case (a)
      17'h000: return {28'b0, |(m_stat & m_en), 1'b0, m_abort, m_exec};
      17'h004: return {28'b0, m_op};
      17'h008: return {28'b0, m_loc};
      17'h00C: return {21'b0, m_len};
      17'h010: return {30'b0, m_en};
      17'h014: return {30'b0, m_stat};
      default: return 32'hBADFABAC;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [16:0] a);
    if (is_ram(a)) return !m_exec;
    return we && !(a == 17'h010 || a == 17'h014 || a == 17'h040);
  endfunction

  task automatic model_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_ram(a) && m_exec)
      for (int b = 0; b < 4; b++) if (s[b]) shadow[a[10:2]][8*b +: 8] = d[8*b +: 8];
    if (a == 17'h010 && s[0]) m_en = d[1:0];
    if (a == 17'h014 && s[0]) m_stat = m_stat & ~d[1:0];
  endtask

  task automatic xfer(input string n, input logic we, input logic [16:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] ed, input logic ee, input logic c);
    int k;
    q.push_back('{n, ed, ee, c});
    @(posedge wb_clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    k = 0;
    do begin @(posedge wb_clk); #1; k++; end while (!wb_ack_o && k < 8);
    if (!wb_ack_o) dchk({n, "_ack_timeout"}, 0, 1);
    else dchk({n, "_ack_latency"}, k, 1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic op(input string n, input logic we, input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] ed;
    logic ee;
    ed = model_rd(a);
    ee = model_err(we, a);
    xfer(n, we, a, d, s, ed, ee, !we);
    if (we) model_wr(a, d, s);
  endtask

  task automatic set_exec(input logic v, input logic [3:0] o, input logic [3:0] l, input logic [10:0] n);
    if (v && !m_exec) begin op_type_i = o; locality_i = l; buf_len_i = n; end
    exec_a_i = v;
    repeat (5) @(posedge wb_clk);
    #1;
    if (v && !m_exec) begin m_stat[0] = 1; m_op = o; m_loc = l; m_len = n; end
    m_exec = v;
  endtask

  task automatic set_abort(input logic v);
    abort_a_i = v;
    repeat (5) @(posedge wb_clk);
    #1;
    if (v && !m_abort) m_stat[1] = 1;
    m_abort = v;
  endtask

  function automatic logic [16:0] pick_reg(input int i);
    case (i)
      0: return 17'h000; 1: return 17'h004; 2: return 17'h008; 3: return 17'h00C;
      4: return 17'h010; 5: return 17'h014; 6: return 17'h040; 7: return 17'h020;
      8: return 17'h018; 9: return 17'h01000; default: return 17'h1F000;
    endcase
  endfunction

  function automatic logic [16:0] ram_adr();
    return 17'h00800 | {6'b0, 9'($urandom), 2'b00};
  endfunction

  initial begin
    int k, base, rb, wb;
    for (int i = 0; i < 512; i++) shadow[i] = 32'(i) * 32'h9E3779B1;
    repeat (3) @(posedge wb_clk);
    #1;
    dchk("rst_ack", wb_ack_o, 0);
    dchk("rst_err", wb_err_o, 0);
    dchk("rst_complete", complete_o, 0);
    dchk("rst_irq", irq_o, 0);
    dchk("rst_wen", ram_wen_o, 0);
    nrst_i = 1;
    op("rst_status", 0, 17'h000, 0, 4'hF);
    op("rst_op", 0, 17'h004, 0, 4'hF);
    op("rst_en", 0, 17'h010, 0, 4'hF);

    op("en_exec", 1, 17'h010, 32'h1, 4'hF);
    @(posedge wb_clk); #1;
    op_type_i = 4'h3; locality_i = 4'h1; buf_len_i = 11'h0A4;
    exec_a_i = 1;
    k = 0;
    do begin @(posedge wb_clk); #1; k++; end while (!irq_o && k < 10);
    dchk("irq_within_4", k <= 4 && irq_o, 1);
    m_stat[0] = 1; m_op = 4'h3; m_loc = 4'h1; m_len = 11'h0A4; m_exec = 1;
    repeat (2) @(posedge wb_clk);
    op("status_exec", 0, 17'h000, 0, 4'hF);
    op("op_type", 0, 17'h004, 0, 4'hF);
    op("locality", 0, 17'h008, 0, 4'hF);
    op("buf_size", 0, 17'h00C, 0, 4'hF);
    op("w1c_exec", 1, 17'h014, 32'h1, 4'hF);
    @(posedge wb_clk); #1;
    dchk("irq_cleared", irq_o, 0);

    base = hi_cnt; rb = rises;
    op("cpl_first", 1, 17'h040, 0, 4'hF);
    repeat (8) @(posedge wb_clk);
    op("cpl_during", 1, 17'h040, 0, 4'hF);
    repeat (30) @(posedge wb_clk);
    #1;
    dchk("cpl_width", hi_cnt - base, 20);
    dchk("cpl_single_pulse", rises - rb, 1);
    base = hi_cnt; rb = rises;
    op("cpl_restart", 1, 17'h040, 0, 4'h1);
    repeat (30) @(posedge wb_clk);
    #1;
    dchk("cpl_restart_width", hi_cnt - base, 20);
    dchk("cpl_restart_pulse", rises - rb, 1);

    wb = wen_cnt;
    op("ram_wr", 1, 17'h00804, 32'hDEADBEEF, 4'b0110);
    dchk("ram_wen_cycles", wen_cnt - wb, 1);
    dchk("ram_wen_val", last_wen, 4'b0110);
    dchk("ram_adr_val", last_adr, 1);
    op("ram_rd", 0, 17'h00804, 0, 4'hF);

    set_exec(0, 0, 0, 0);
    wb = wen_cnt;
    op("ram_wr_blocked", 1, 17'h00800, 32'h12345678, 4'hF);
    dchk("ram_wen_blocked", wen_cnt - wb, 0);
    op("ram_rd_blocked", 0, 17'h00800, 0, 4'hF);
    op("unmapped_rd", 0, 17'h00020, 0, 4'hF);
    op("ro_wr", 1, 17'h004, 32'hF, 4'hF);
    op("op_after_ro_wr", 0, 17'h004, 0, 4'hF);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: set_exec(!m_exec, 4'($urandom), 4'($urandom), 11'($urandom));
        1: set_abort(!m_abort);
        2: op("rnd_en_wr", 1, 17'h010, $urandom, 4'hF);
        3: op("rnd_w1c", 1, 17'h014, $urandom, 4'hF);
        4, 5: op("rnd_ram_wr", 1, ram_adr(), $urandom, 4'($urandom));
        6, 7: op("rnd_ram_rd", 0, ram_adr(), 0, 4'hF);
        8: op("rnd_reg_rd", 0, pick_reg($urandom_range(0, 10)), 0, 4'hF);
        default: op("rnd_bad_wr", 1, pick_reg($urandom_range(0, 3) == 0 ? 7 : $urandom_range(0, 3)), $urandom, 4'hF);
      endcase
      repeat (2) @(posedge wb_clk);
      #1;
      dchk("rnd_irq", irq_o, |(m_stat & m_en));
    end

    if (m_abort) set_abort(0);
    @(posedge wb_clk); #1;
    abort_a_i = 1;
    @(posedge wb_clk);
    op("w1c_vs_abort", 1, 17'h014, 32'h2, 4'hF);
    m_stat[1] = 1; m_abort = 1;
    op("abort_set_wins", 0, 17'h014, 0, 4'hF);

    op("en_all", 1, 17'h010, 32'h3, 4'hF);
    op("cpl_pre_rst", 1, 17'h040, 0, 4'hF);
    repeat (5) @(posedge wb_clk);
    #2;
    dchk("pre_rst_complete", complete_o, 1);
    dchk("pre_rst_irq", irq_o, 1);
    nrst_i = 0;
    #1;
    dchk("midrst_complete", complete_o, 0);
    dchk("midrst_irq", irq_o, 0);
    dchk("midrst_ack", wb_ack_o, 0);
    exec_a_i = 0; abort_a_i = 0;
    #20;
    @(posedge wb_clk); #1;
    nrst_i = 1;
    m_en = 0; m_stat = 0; m_op = 0; m_loc = 0; m_len = 0; m_exec = 0; m_abort = 0;
    repeat (5) @(posedge wb_clk);
    op("post_rst_status", 0, 17'h000, 0, 4'hF);
    op("post_rst_op", 0, 17'h004, 0, 4'hF);
    op("post_rst_buf", 0, 17'h00C, 0, 4'hF);
    op("post_rst_en", 0, 17'h010, 0, 4'hF);

    repeat (4) @(posedge wb_clk);
    dchk("scoreboard_drained", q.size(), 0);
    repeat (2) @(negedge wb_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/twpm_cmd_mailbox.md
Name: twpm_cmd_mailbox

Overview:
- Wishbone slave on the NeoRV32 side; sits between the CPU Wishbone master and the LPC-domain TPM register block / shared 512x32 RAM.
- Synchronises exec/abort from the LCLK domain into wb_clk, snapshots command metadata, raises a CPU interrupt, and exposes the mailbox registers.
- Gates CPU access to the RAM window and generates the fixed-width `complete` pulse back to the LPC side.

Parameters:
- RAM_ADDR_WIDTH, 11, byte-address width of the RAM window (2 KiB).
- COMPLETE_PULSE_WIDTH, 20, `complete_o` high time in wb_clk cycles (1..255).
- DEFAULT_READ_VALUE, 32'hBADFABAC, read data for unmapped or blocked reads.

Ports:
- wb_clk  in  1  Wishbone/CPU clock
- nrst_i  in  1  reset; asynchronous, active-low
- wb_adr_i  in  17  byte address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte enables
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  transfer ack
- wb_err_o  out  1  transfer error, same cycle as ack
- exec_a_i  in  1  exec flag, LCLK domain (async)
- abort_a_i  in  1  abort flag, LCLK domain (async)
- op_type_i  in  4  command op type; stable while exec=1
- locality_i  in  4  command locality; stable while exec=1
- buf_len_i  in  RAM_ADDR_WIDTH  command length; stable while exec=1
- ram_rd_i  in  32  RAM read data (synchronous RAM, 1-cycle latency)
- ram_adr_o  out  RAM_ADDR_WIDTH-2  RAM word address (= wb_adr_i[RAM_ADDR_WIDTH-1:2])
- ram_wen_o  out  4  RAM byte write enables
- complete_o  out  1  completion pulse to the LPC side
- irq_o  out  1  level interrupt to the CPU

Behaviour:
- Reset values: wb_ack_o=0, wb_err_o=0, complete_o=0, irq_o=0, ram_wen_o=0, all snapshots=0, IRQ_EN=0, IRQ_STAT=0, pulse counter=0, synchroniser flops=0.
- Synchronisers: exec and abort each pass through 2 flops (exec_s, abort_s). A rising edge is detected against a third flop, so detection latency is 3 wb_clk cycles.
- On exec_s rising edge: capture op_type_i, locality_i and buf_len_i into snapshot registers; set IRQ_STAT[0].
- On abort_s rising edge: set IRQ_STAT[1].
- irq_o is registered: irq_o = |(IRQ_STAT & IRQ_EN[1:0]).
- Ack: wb_ack_o <= cyc & stb & ~wb_ack_o. Every access takes exactly one wait state and acks on cycle 2.
- Side effects: writes take effect only on the cycle where cyc & stb & we & ~ack, so each write happens once.
- Register map (word-aligned, wb_adr_i[16:2] decode):
  - 0x000 STATUS RO: {28'b0, irq_o, complete_o, abort_s, exec_s}
  - 0x004 OP_TYPE RO: snapshot, zero-extended
  - 0x008 LOCALITY RO: snapshot, zero-extended
  - 0x00C BUF_SIZE RO: snapshot, zero-extended
  - 0x010 IRQ_EN RW: bits[1:0]; other bits read 0
  - 0x014 IRQ_STAT W1C: bits[1:0]
  - 0x040 COMPLETE WO: any write with wb_sel_i != 0
- RAM window: wb_adr_i[16:RAM_ADDR_WIDTH] == 17'h00800 >> RAM_ADDR_WIDTH.
  - Read data: wb_dat_o = ram_rd_i, valid in the ack cycle.
  - Write: ram_wen_o = wb_sel_i in the write cycle only.
  - Access is allowed only while exec_s=1. When exec_s=0 the LPC side owns the RAM: ram_wen_o stays 0, reads return DEFAULT_READ_VALUE, and the access acks with wb_err_o=1.
- Other errors: unmapped reads return DEFAULT_READ_VALUE with err=0. Writes to RO or unmapped addresses are dropped and ack with err=1.
- Complete counter (8-bit):
  - Write to COMPLETE while counter==0 loads COMPLETE_PULSE_WIDTH.
  - Write while counter!=0 is ignored (ack, err=0).
  - Otherwise the counter decrements and saturates at 0.
  - complete_o = (counter != 0), registered. The pulse is exactly COMPLETE_PULSE_WIDTH cycles.
- Simultaneous events:
  - A W1C clear and a new edge on the same bit in the same cycle: set wins.
  - exec_s falling during the pulse does not stop the pulse.
- Reset mid-operation: asynchronous reset clears an in-flight ack, pulse and snapshots immediately. No write is half-applied.

Decomposition:
- Package twpm_pkg holds:
  - register address constants (STATUS, OP_TYPE, LOCALITY, BUF_SIZE, IRQ_EN, IRQ_STAT, COMPLETE, FPGA_RAM_BASE)
  - DEFAULT_READ_VALUE
  - IRQ bit indices (IRQ_EXEC=0, IRQ_ABORT=1)
- One sub-module: twpm_sync_edge, a 2-flop synchroniser plus rising-edge detector with async active-low reset. It is instantiated twice (exec, abort).

Test Plan:
- Raise exec_a_i with op_type=4'h3, locality=4'h1, buf_len=11'h0A4, IRQ_EN=2'b01 -> irq_o rises within 4 cycles; reads give STATUS bit0=1, OP_TYPE=0x3, LOCALITY=0x1, BUF_SIZE=0x0A4. Write IRQ_STAT=1 -> irq_o=0 on the next cycle.
- Write COMPLETE -> complete_o is high for exactly 20 cycles. A second COMPLETE write at cycle 10 does not extend the pulse. A write after the pulse ends restarts it.
- exec=1: write 0xDEADBEEF with sel=4'b0110 to 0x00804 -> ram_wen_o=4'b0110 for one cycle, ram_adr_o=1. A read of 0x00804 returns ram_rd_i in the ack cycle, err=0.
- exec=0: write to 0x00800 -> ram_wen_o stays 0 and ack with err=1. A read returns 0xBADFABAC with err=1.
- Read 0x00020 -> 0xBADFABAC, err=0. Write to OP_TYPE -> err=1, value unchanged.
- Assert abort_a_i in the same cycle as a W1C of IRQ_STAT[1] -> bit remains set. Assert nrst_i low mid-pulse -> complete_o=0, irq_o=0, ack=0 immediately.
